// File: rtl/cr16_alu_mc_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the CR16 multi-cycle ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cr16_alu_mc_pkg;

  // Opcode encodings
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_LSH  = 4'd7;
  localparam logic [3:0] OP_ASHU = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  // Bit positions inside the {C,L,F,Z,N} flag word
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only the arithmetic/compare ops update the flags register.
  function automatic logic op_writes_flags(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/cr16_mul_iter.sv
// Iterative unsigned shift-add multiplier, low P_WIDTH bits of the product.
// Latency: P_WIDTH cycles after start_i; done_o flags the edge that retires the last partial product.
// Backpressure: none; start_i must only be pulsed while idle (the parent guarantees this).
module cr16_mul_iter #(
  parameter int P_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [P_WIDTH-1:0] a_i,
  input  logic [P_WIDTH-1:0] b_i,
  output logic [P_WIDTH-1:0] product_o,
  output logic               done_o
);

  localparam int CW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(P_WIDTH - 1);

  logic [P_WIDTH-1:0] mcand_q, mcand_d;
  logic [P_WIDTH-1:0] mplier_q, mplier_d;
  logic [P_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;
  logic [P_WIDTH-1:0] acc_next;

  // Accumulator after adding this cycle's partial product; this is the
  // final product on the cycle done_o is high.
  always_comb begin
    acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_o    = run_q && (cnt_q == LAST);
    product_o = acc_next;
  end

  // Next-state: load operands on start, otherwise retire one multiplier bit per cycle
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done_o) begin
        run_d = 1'b0;
      end
    end
  end

  // Iteration state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/cr16_alu_mc.sv
// CR16 execute-stage ALU: single-cycle ops plus iterative MUL, with merged flag output for the flags register.
// Latency: 1 cycle for non-MUL ops, P_WIDTH+1 cycles for MUL; all outputs registered.
// Backpressure: I_START is ignored while O_BUSY=1; a new start is accepted in the DONE cycle.
module cr16_alu_mc
  import cr16_alu_mc_pkg::*;
#(
  parameter int P_WIDTH      = 16,
  parameter int P_FLAG_WIDTH = 5
) (
  input  logic                    I_CLK,
  input  logic                    I_NRESET,
  input  logic                    I_START,
  input  logic [3:0]              I_OPCODE,
  input  logic [P_WIDTH-1:0]      I_A,
  input  logic [P_WIDTH-1:0]      I_B,
  input  logic [P_FLAG_WIDTH-1:0] I_FLAGS,
  output logic [P_WIDTH-1:0]      O_RESULT,
  output logic [P_FLAG_WIDTH-1:0] O_FLAGS,
  output logic                    O_FLAGS_WE,
  output logic                    O_BUSY,
  output logic                    O_DONE
);

  localparam int MSB = P_WIDTH - 1;

  state_e state_q, state_d;

  logic [P_WIDTH-1:0]      result_q, result_d;
  logic [P_FLAG_WIDTH-1:0] flags_q, flags_d;
  logic [P_FLAG_WIDTH-1:0] hold_q, hold_d;
  logic                    we_q, we_d;

  logic                    accept;
  logic                    mul_start;
  logic                    mul_done;
  logic [P_WIDTH-1:0]      mul_product;

  logic [P_WIDTH:0]        add_w;
  logic [P_WIDTH:0]        sub_w;
  logic                    add_ovf;
  logic                    sub_ovf;
  logic [4:0]              sh_mag;
  logic                    sh_neg;
  logic                    sh_big;
  logic [P_WIDTH-1:0]      sh_res;
  logic [P_WIDTH-1:0]      alu_res;
  logic [P_FLAG_WIDTH-1:0] alu_flags;

  assign accept    = I_START && (state_q != ST_MUL);
  assign mul_start = accept && (I_OPCODE == OP_MUL);

  cr16_mul_iter #(.P_WIDTH(P_WIDTH)) u_mul (
    .clk_i     (I_CLK),
    .rst_ni    (I_NRESET),
    .start_i   (mul_start),
    .a_i       (I_A),
    .b_i       (I_B),
    .product_o (mul_product),
    .done_o    (mul_done)
  );

  // FSM state register
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: IDLE and DONE both accept a new operation
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = (I_OPCODE == OP_MUL) ? ST_MUL : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register only
  always_comb begin
    O_BUSY = (state_q == ST_MUL);
    O_DONE = (state_q == ST_DONE);
  end

  // Arithmetic helpers; operands are zero-extended so the top bit is carry/borrow
  always_comb begin
    add_w   = {1'b0, I_A} + {1'b0, I_B};
    sub_w   = {1'b0, I_A} - {1'b0, I_B};
    add_ovf = (I_A[MSB] == I_B[MSB]) && (add_w[MSB] != I_A[MSB]);
    sub_ovf = (I_A[MSB] != I_B[MSB]) && (sub_w[MSB] != I_A[MSB]);
  end

  // Shifter: B[4:0] is a signed count, negative means shift right
  always_comb begin
    sh_neg = I_B[4];
    sh_mag = sh_neg ? (5'd0 - I_B[4:0]) : I_B[4:0];
    sh_big = (int'(sh_mag) >= P_WIDTH);
    if (!sh_neg) begin
      sh_res = sh_big ? '0 : (I_A << sh_mag);
    end else if (I_OPCODE == OP_ASHU) begin
      sh_res = sh_big ? {P_WIDTH{I_A[MSB]}} : $unsigned($signed(I_A) >>> sh_mag);
    end else begin
      sh_res = sh_big ? '0 : (I_A >> sh_mag);
    end
  end

  // Single-cycle result and flag merge; untouched flag bits pass through from I_FLAGS
  always_comb begin
    alu_res   = '0;
    alu_flags = I_FLAGS;
    case (I_OPCODE)
      OP_ADD: begin
        alu_res           = add_w[MSB:0];
        alu_flags[FLAG_C] = add_w[P_WIDTH];
        alu_flags[FLAG_F] = add_ovf;
      end
      OP_SUB: begin
        alu_res           = sub_w[MSB:0];
        alu_flags[FLAG_C] = sub_w[P_WIDTH];
        alu_flags[FLAG_F] = sub_ovf;
      end
      OP_CMP: begin
        alu_res           = I_A;
        alu_flags[FLAG_L] = (I_A < I_B);
        alu_flags[FLAG_N] = ($signed(I_A) < $signed(I_B));
        alu_flags[FLAG_Z] = (I_A == I_B);
      end
      OP_AND:           alu_res = I_A & I_B;
      OP_OR:            alu_res = I_A | I_B;
      OP_XOR:           alu_res = I_A ^ I_B;
      OP_MOV:           alu_res = I_B;
      OP_LSH, OP_ASHU:  alu_res = sh_res;
      default:          alu_res = '0;
    endcase
  end

  // Output next-state: results change only on completion; MUL keeps its sampled flags aside
  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    hold_d   = hold_q;
    we_d     = 1'b0;
    if (state_q == ST_MUL) begin
      if (mul_done) begin
        result_d = mul_product;
        flags_d  = hold_q;
      end
    end else if (I_START) begin
      if (I_OPCODE == OP_MUL) begin
        hold_d = I_FLAGS;
      end else begin
        result_d = alu_res;
        flags_d  = alu_flags;
        we_d     = op_writes_flags(I_OPCODE);
      end
    end
  end

  // Output registers
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      result_q <= '0;
      flags_q  <= '0;
      hold_q   <= '0;
      we_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      hold_q   <= hold_d;
      we_q     <= we_d;
    end
  end

  assign O_RESULT   = result_q;
  assign O_FLAGS    = flags_q;
  assign O_FLAGS_WE = we_q;

endmodule

// File: tb/tb_cr16_alu_mc.sv
// Directed and randomised bench for cr16_alu_mc with a completion scoreboard.
// Latency: checks 1-cycle and 17-cycle (MUL) completion timing.
// Backpressure: exercises starts while busy and back-to-back starts in DONE.
module tb_cr16_alu_mc;

  typedef struct {
    logic [15:0] r;
    logic [4:0]  f;
    logic        we;
  } exp_t;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic [4:0]  flags_in;
  logic [15:0] o_result;
  logic [4:0]  o_flags;
  logic        o_we;
  logic        o_busy;
  logic        o_done;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  cr16_alu_mc #(.P_WIDTH(16), .P_FLAG_WIDTH(5)) dut (
    .I_CLK      (clk),
    .I_NRESET   (nrst),
    .I_START    (start),
    .I_OPCODE   (opcode),
    .I_A        (a),
    .I_B        (b),
    .I_FLAGS    (flags_in),
    .O_RESULT   (o_result),
    .O_FLAGS    (o_flags),
    .O_FLAGS_WE (o_we),
    .O_BUSY     (o_busy),
    .O_DONE     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model written independently with integer arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                                 input logic [4:0] fl);
    exp_t e;
    int ix, iy, sx, sy, t, sh;
    logic signed [4:0] s5;
    longint p;
    ix = int'(x);
    iy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    e.r = 16'h0;
    e.f = fl;
    e.we = 1'b0;
    case (op)
      4'd0: begin
        t = ix + iy;
        e.r = 16'(t);
        e.f[4] = (t > 65535);
        e.f[2] = ((sx + sy) > 32767) || ((sx + sy) < -32768);
        e.we = 1'b1;
      end
      4'd1: begin
        t = ix - iy;
        e.r = 16'(t);
        e.f[4] = (ix < iy);
        e.f[2] = ((sx - sy) > 32767) || ((sx - sy) < -32768);
        e.we = 1'b1;
      end
      4'd2: begin
        e.r = x;
        e.f[3] = (ix < iy);
        e.f[0] = (sx < sy);
        e.f[1] = (ix == iy);
        e.we = 1'b1;
      end
      4'd3: e.r = x & y;
      4'd4: e.r = x | y;
      4'd5: e.r = x ^ y;
      4'd6: e.r = y;
      4'd7, 4'd8: begin
        s5 = y[4:0];
        sh = int'(s5);
        if (sh >= 0) begin
          e.r = (sh >= 16) ? 16'h0 : (x << sh);
        end else begin
          e.r = x;
          for (int k = 0; k < -sh; k++) begin
            e.r = {(op == 4'd8) ? e.r[15] : 1'b0, e.r[15:1]};
          end
        end
      end
      4'd9: begin
        p = longint'(ix) * longint'(iy);
        e.r = 16'(p);
      end
      default: e.r = 16'h0;
    endcase
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] r, input logic [4:0] f, input logic we);
    exp_t e;
    e.r = r;
    e.f = f;
    e.we = we;
    return e;
  endfunction

  // Drive one start pulse; returns at the first negedge after the accepting edge
  task automatic issue(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [4:0] fl, input exp_t e);
    @(negedge clk);
    opcode = op;
    a = x;
    b = y;
    flags_in = fl;
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 1;
    while (!o_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!o_done) chk(tag, 32'd0, 32'd1);
  endtask

  // Scoreboard: every completion pops and compares one expectation
  always @(negedge clk) begin
    if (nrst) begin
      if (o_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_result", 32'(o_result), 32'(e.r));
          chk("sb_flags", 32'(o_flags), 32'(e.f));
          chk("sb_we", 32'(o_we), 32'(e.we));
        end
      end else if (o_we) begin
        chk("we_without_done", 32'(o_we), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int busy_cnt;
    logic [3:0] op;
    logic [15:0] ra, rb;
    logic [4:0] rf;

    nrst = 1'b0;
    start = 1'b0;
    opcode = 4'd0;
    a = 16'h0;
    b = 16'h0;
    flags_in = 5'h0;
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(o_result), 32'd0);
    chk("rst_flags", 32'(o_flags), 32'd0);
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // ADD with carry out, no overflow
    issue(4'd0, 16'hFFFF, 16'h0001, 5'h00, mk(16'h0000, 5'h10, 1'b1));
    chk("add_latency", 32'(o_done), 32'd1);
    // SUB with signed overflow, L/Z/N kept
    issue(4'd1, 16'h8000, 16'h0001, 5'h0B, mk(16'h7FFF, 5'h0F, 1'b1));
    // CMP unsigned-less but signed-greater
    issue(4'd2, 16'h0001, 16'hFFFF, 5'h00, mk(16'h0001, 5'h08, 1'b1));
    // Shifts from the plan and at the count boundaries
    issue(4'd7, 16'h00F0, 16'h001C, 5'h15, mk(16'h000F, 5'h15, 1'b0));
    issue(4'd8, 16'h8000, 16'h001F, 5'h00, mk(16'hC000, 5'h00, 1'b0));
    issue(4'd7, 16'h1234, 16'h0010, 5'h00, mk(16'h0000, 5'h00, 1'b0));
    issue(4'd8, 16'h8001, 16'h0010, 5'h00, mk(16'hFFFF, 5'h00, 1'b0));
    issue(4'd7, 16'h0001, 16'h000F, 5'h00, mk(16'h8000, 5'h00, 1'b0));
    // Undefined opcode
    issue(4'hC, 16'hABCD, 16'h1234, 5'h1A, mk(16'h0000, 5'h1A, 1'b0));

    // Back-to-back starts in the DONE cycle
    @(negedge clk);
    opcode = 4'd3; a = 16'hF0F0; b = 16'h3C3C; flags_in = 5'h03; start = 1'b1;
    sb.push_back(mk(16'h3030, 5'h03, 1'b0));
    @(negedge clk);
    chk("b2b_done1", 32'(o_done), 32'd1);
    opcode = 4'd4; a = 16'hF0F0; b = 16'h0F01; flags_in = 5'h04;
    sb.push_back(mk(16'hFFF1, 5'h04, 1'b0));
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done2", 32'(o_done), 32'd1);

    // MUL: busy for 16 cycles, done 17 cycles after the start cycle, mid-run start ignored
    issue(4'd9, 16'h0123, 16'h0045, 5'h1F, mk(16'h4E6F, 5'h1F, 1'b0));
    cyc = 1;
    busy_cnt = 0;
    while (1) begin
      if (o_busy) busy_cnt++;
      if (o_done || cyc >= 40) break;
      if (cyc == 8) begin
        opcode = 4'd0; a = 16'h1111; b = 16'h2222; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      flags_in = 5'h00;
      @(negedge clk);
      cyc++;
    end
    chk("mul_latency", 32'(cyc), 32'd17);
    chk("mul_busy_cycles", 32'(busy_cnt), 32'd16);
    @(negedge clk);
    chk("mul_result_held", 32'(o_result), 32'h4E6F);
    chk("mul_done_pulse", 32'(o_done), 32'd0);

    // Random mix against the model
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rf = 5'($urandom);
      issue(op, ra, rb, rf, model(op, ra, rb, rf));
      wait_done("rand_timeout");
    end

    // Reset in the middle of a MUL aborts it with no clock edge needed
    @(negedge clk);
    opcode = 4'd9; a = 16'h7777; b = 16'h5555; flags_in = 5'h1F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("arst_result", 32'(o_result), 32'd0);
    chk("arst_flags", 32'(o_flags), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_done", 32'(o_done), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    issue(4'd5, 16'h5A5A, 16'hFF00, 5'h09, model(4'd5, 16'h5A5A, 16'hFF00, 5'h09));
    chk("xor_after_reset_latency", 32'(o_done), 32'd1);

    repeat (25) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
